// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional leading-zero blanking mask enabled by defining BIN_TO_BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  INIT,
  input  logic [WIDTH-1:0]      BIN_IN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD_OUT,
  output logic [DIGITS-1:0]     BLANK
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t                state;
  logic [WIDTH-1:0]      bin_sr;
  logic [4*DIGITS-1:0]   bcd_sr;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   bcd_corr;
  logic [4*DIGITS-1:0]   bcd_shift;
  logic [DIGITS-1:0]     blank_next;

  // Add-3 correction on every digit, then shift in the next binary MSB.
  always_comb begin
    bcd_corr = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5)
        bcd_corr[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      else
        bcd_corr[4*i +: 4] = bcd_sr[4*i +: 4];
    end
    bcd_shift = {bcd_corr[4*DIGITS-2:0], bin_sr[WIDTH-1]};
  end

`ifdef BIN_TO_BCD_BLANK_EN
  // Digit i is blanked when it and every digit above it is zero; units never blank.
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    blank_next = '0;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero & (bcd_shift[4*i +: 4] == 4'd0);
      blank_next[i] = all_zero;
    end
  end
`else
  always_comb begin
    blank_next = '0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      BCD_OUT <= '0;
      BLANK   <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (INIT) begin
            bin_sr <= BIN_IN;
            bcd_sr <= '0;
            cnt    <= CW'(WIDTH);
            BUSY   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_shift;
          bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            BCD_OUT <= bcd_shift;
            BLANK   <= blank_next;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state   <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, corner sequences and
// random operands against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        INIT = 1'b0;
  logic [15:0] BIN_IN = '0;
  logic        BUSY;
  logic        DONE;
  logic [19:0] BCD_OUT;
  logic [4:0]  BLANK;

  int checks = 0;
  int failures = 0;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .reset(reset), .INIT(INIT), .BIN_IN(BIN_IN),
    .BUSY(BUSY), .DONE(DONE), .BCD_OUT(BCD_OUT), .BLANK(BLANK)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blank;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] model_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] model_blank(input int v);
    logic [4:0] r;
    int lim;
    r = '0;
    lim = 1;
`ifdef BIN_TO_BCD_BLANK_EN
    for (int i = 1; i < 5; i++) begin
      lim = lim * 10;
      r[i] = (v < lim);
    end
`endif
    return r;
  endfunction

  function automatic logic [4:0] en_blank(input logic [4:0] b);
`ifdef BIN_TO_BCD_BLANK_EN
    return b;
`else
    return b & 5'b0;
`endif
  endfunction

  // One full conversion; lat counts edges from the accepting edge to DONE.
  task automatic convert(input logic [15:0] v, output logic [19:0] bcd,
                         output logic [4:0] blk, output int lat, output int busy_cnt);
    @(negedge clk);
    BIN_IN = v;
    INIT   = 1'b1;
    @(negedge clk);
    INIT   = 1'b0;
    BIN_IN = 16'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!DONE && lat < 40) begin
      if (BUSY) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    bcd = BCD_OUT;
    blk = BLANK;
  endtask

  initial begin
    vec_t tbl[8];
    logic [19:0] bcd;
    logic [4:0]  blk;
    int lat, busy_cnt, dones, cyc, t1, t2;
    logic [15:0] v;

    tbl[0] = '{16'd0,     20'h00000, 5'b11110};
    tbl[1] = '{16'd65535, 20'h65535, 5'b00000};
    tbl[2] = '{16'd1234,  20'h01234, 5'b10000};
    tbl[3] = '{16'd9,     20'h00009, 5'b11110};
    tbl[4] = '{16'd10,    20'h00010, 5'b11100};
    tbl[5] = '{16'd100,   20'h00100, 5'b11000};
    tbl[6] = '{16'd10000, 20'h10000, 5'b00000};
    tbl[7] = '{16'd59999, 20'h59999, 5'b00000};

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_bcd", 32'(BCD_OUT), 32'd0);
    check("reset_blank", 32'(BLANK), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(BUSY), 32'd0);

    for (int i = 0; i < 8; i++) begin
      convert(tbl[i].bin, bcd, blk, lat, busy_cnt);
      check($sformatf("tbl%0d_bcd", i), 32'(bcd), 32'(tbl[i].bcd));
      check($sformatf("tbl%0d_blank", i), 32'(blk), 32'(en_blank(tbl[i].blank)));
      check($sformatf("tbl%0d_latency", i), lat, 16);
      check($sformatf("tbl%0d_busy_cycles", i), busy_cnt, 16);
      @(negedge clk);
      check($sformatf("tbl%0d_done_width", i), 32'(DONE), 32'd0);
    end

    // INIT during SHIFT must be ignored.
    @(negedge clk);
    BIN_IN = 16'd999;
    INIT = 1'b1;
    @(negedge clk);
    INIT = 1'b0;
    repeat (4) @(negedge clk);
    BIN_IN = 16'd42;
    INIT = 1'b1;
    @(negedge clk);
    INIT = 1'b0;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (DONE) begin
        dones++;
        check("ignore_init_bcd", 32'(BCD_OUT), 32'h00999);
      end
      @(negedge clk);
    end
    check("ignore_init_done_count", dones, 1);

    // Reset mid-conversion aborts with no DONE.
    @(negedge clk);
    BIN_IN = 16'd12345;
    INIT = 1'b1;
    @(negedge clk);
    INIT = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_bcd", 32'(BCD_OUT), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      if (DONE) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);
    convert(16'd4321, bcd, blk, lat, busy_cnt);
    check("post_abort_bcd", 32'(bcd), 32'h04321);
    check("post_abort_latency", lat, 16);

    // INIT held high: back-to-back runs.
    @(negedge clk);
    @(negedge clk);
    BIN_IN = 16'd7;
    INIT = 1'b1;
    @(negedge clk);
    BIN_IN = 16'd10000;
    cyc = 0;
    t1 = -1;
    t2 = -1;
    while (t2 < 0 && cyc < 60) begin
      if (DONE) begin
        if (t1 < 0) begin
          t1 = cyc;
          check("b2b_first_bcd", 32'(BCD_OUT), 32'h00007);
        end else begin
          t2 = cyc;
          INIT = 1'b0;
          check("b2b_second_bcd", 32'(BCD_OUT), 32'h10000);
        end
      end
      if (t2 < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    INIT = 1'b0;
    check("b2b_period", t2 - t1, 18);
    repeat (20) @(negedge clk);

    // Random operands against the decimal model.
    for (int i = 0; i < 150; i++) begin
      v = 16'($urandom);
      if (i % 5 == 0) v = 16'($urandom_range(0, 120));
      convert(v, bcd, blk, lat, busy_cnt);
      check($sformatf("rand_bcd_%0d", v), 32'(bcd), 32'(model_bcd(int'(v))));
      check($sformatf("rand_blank_%0d", v), 32'(blk), 32'(model_blank(int'(v))));
      check($sformatf("rand_latency_%0d", v), lat, 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
